ibex_mem_arbiter: RTL
=====================

# ibex_mem_arbiter

Two-master to one-slave arbiter that shares a single memory port between the core's instruction-fetch and data (LSU) interfaces. It sits between `ibex_core` and a single-ported memory or bus. Round-robin arbitration selects the master, the selection is frozen while a request awaits grant, and a source-ID FIFO routes in-order responses back to the issuing master. The block adds no latency: grant and response paths are combinational.

## Interface
Parameters:
- MaxOutstanding, 2: maximum granted-but-unanswered transactions (1..4); this is the depth of the source-ID FIFO.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- instr_req_i / instr_gnt_o / instr_rvalid_o  in/out/out  1  instruction-side handshake
- instr_addr_i  in  32  fetch address
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch bus error
- data_req_i / data_gnt_o / data_rvalid_o  in/out/out  1  data-side handshake
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i, data_wdata_i  in  32  data address, write data
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data bus error
- mem_req_o, mem_we_o  out  1  memory request, memory write enable
- mem_be_o  out  4  memory byte enables
- mem_addr_o, mem_wdata_o  out  32  memory address, memory write data
- mem_gnt_i, mem_rvalid_i, mem_err_i  in  1  memory grant, response valid, response error
- mem_rdata_i  in  32  memory read data
- outstanding_o  out  $clog2(MaxOutstanding+1)  current FIFO fill level

## Operation
- Protocol on all ports: a request is accepted when req=1 and gnt=1 in the same cycle. Responses return in order, one per accepted request, flagged by rvalid. err is valid only together with rvalid.
- The arbiter FSM has two states:
  - IDLE: no issued, ungranted request.
  - HOLD: mem_req_o was 1 and mem_gnt_i was 0 in the previous cycle.
- Selection in IDLE:
  - Only one master requesting: that master is selected.
  - Both masters requesting: the master indicated by prio_q is selected.
- Selection in HOLD: the selected master is the registered sel_q, regardless of the other master's request.
- Transitions:
  - IDLE→HOLD when mem_req_o=1 and mem_gnt_i=0. sel_q captures the selection.
  - HOLD→IDLE on mem_gnt_i=1.
  - HOLD→IDLE if the held master drops its req (protocol violation; mem_req_o follows the drop).
- prio_q resets to data. On every granted transfer, prio_q is set to the master that was not granted.
- Request muxing:
  - mem_req_o = selected master's req AND (count < MaxOutstanding).
  - For the data master, mem_addr/we/be/wdata are the data_* inputs.
  - For the instruction master, mem_addr is instr_addr_i, we=0, be=4'hF, wdata=0.
  - The selected master's gnt_o = mem_gnt_i & mem_req_o. The other master's gnt_o = 0.
- FIFO behaviour:
  - Push the selected ID on mem_req_o & mem_gnt_i.
  - Pop on mem_rvalid_i when count>0.
  - Push and pop in the same cycle leave count unchanged.
  - A full FIFO blocks new issue. There is no same-cycle pop bypass.
- Response routing:
  - The head ID's rvalid_o = mem_rvalid_i. The same applies to err_o, gated by mem_rvalid_i.
  - Both rdata_o = mem_rdata_i unconditionally.
- mem_rvalid_i while count=0 is a spurious response. It is dropped: no rvalid_o, count stays 0. Simulation assertion flags it.
- mem_gnt_i while mem_req_o=0 is ignored.

## Timing
- Reset values:
  - count=0, FSM IDLE, prio_q=data, FIFO pointers 0.
  - With idle inputs, every output is 0. This includes mem_* and outstanding_o.
- Latency:
  - req→mem_req_o: 0 cycles.
  - mem_gnt_i→master gnt: 0 cycles.
  - mem_rvalid_i→master rvalid: 0 cycles.
  - Back-to-back grants are allowed every cycle while count < MaxOutstanding.
- The address and attributes of a held request are stable from first assertion until grant, as long as the master holds its inputs stable.
- outstanding_o is registered and reflects the count after the previous edge.
- Reset mid-operation discards all outstanding IDs. Responses arriving afterwards are spurious and dropped.

## Test plan
- Single write: data_req_i=1, addr=0x100, we=1, be=4'hF, wdata=0xDEADBEEF, mem_gnt_i=1.
  - Same cycle: mem_* mirrors the inputs, data_gnt_o=1, instr_gnt_o=0.
  - Next cycle, mem_rvalid_i=1: data_rvalid_o=1, instr_rvalid_o=0, outstanding returns 1→0.
- Contention after reset: both requests with mem_gnt_i=1 constant.
  - Data is granted in cycle 0, instr in cycle 1, data in cycle 2 (alternation).
  - Two subsequent rvalids route to data, then instr.
- Hold: data granted first, then both request, instr is selected, mem_gnt_i=0 for 3 cycles.
  - mem_addr_o stays at instr_addr_i for all 3 cycles and mem_we_o=0.
  - data_gnt_o stays 0. On the 4th cycle, gnt goes to instr.
- Full: MaxOutstanding=2, two grants with no rvalid, data_req_i held.
  - Third cycle: mem_req_o=0, outstanding_o=2.
  - mem_rvalid_i for one response: mem_req_o=1 on the following cycle.
- Error routing: instruction outstanding, then mem_rvalid_i=1 with mem_err_i=1 and mem_rdata_i=0x12345678.
  - instr_rvalid_o=1, instr_err_o=1, data_err_o=0.
- Reset mid-operation: one data transaction outstanding, rst_ni pulsed low, then mem_rvalid_i=1.
  - No rvalid_o is asserted, outstanding_o=0, and the next simultaneous request grants data.

Source files
------------

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: round-robin instr/data arbiter onto one memory port with in-order response routing
module ibex_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  instr_req_i,
    output logic                                  instr_gnt_o,
    output logic                                  instr_rvalid_o,
    input  logic [31:0]                           instr_addr_i,
    output logic [31:0]                           instr_rdata_o,
    output logic                                  instr_err_o,
    input  logic                                  data_req_i,
    output logic                                  data_gnt_o,
    output logic                                  data_rvalid_o,
    input  logic                                  data_we_i,
    input  logic [3:0]                            data_be_i,
    input  logic [31:0]                           data_addr_i,
    input  logic [31:0]                           data_wdata_i,
    output logic [31:0]                           data_rdata_o,
    output logic                                  data_err_o,
    output logic                                  mem_req_o,
    output logic                                  mem_we_o,
    output logic [3:0]                            mem_be_o,
    output logic [31:0]                           mem_addr_o,
    output logic [31:0]                           mem_wdata_o,
    input  logic                                  mem_gnt_i,
    input  logic                                  mem_rvalid_i,
    input  logic                                  mem_err_i,
    input  logic [31:0]                           mem_rdata_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e                    state_q, state_d;
    logic                      sel, sel_q, prio_q, sel_req, push, pop, head;
    logic [CW-1:0]             count_q;
    logic [PW-1:0]             wr_q, rd_q;
    logic [MaxOutstanding-1:0] ids_q;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // sel is 1 for the data master; with no requester it parks on data so idle outputs stay 0
    always_comb begin
        sel     = (state_q == HOLD) ? sel_q : (!instr_req_i || (data_req_i && prio_q));
        sel_req = sel ? data_req_i : instr_req_i;
        state_d = state_q;
        if (state_q == IDLE && sel_req && count_q != CW'(MaxOutstanding) && !mem_gnt_i)
            state_d = HOLD;
        if (state_q == HOLD && (mem_gnt_i || !sel_req))
            state_d = IDLE;
    end

    always_comb begin
        mem_req_o      = sel_req && (count_q != CW'(MaxOutstanding));
        mem_we_o       = sel && data_we_i;
        mem_be_o       = sel ? data_be_i : 4'hF;
        mem_addr_o     = sel ? data_addr_i : instr_addr_i;
        mem_wdata_o    = sel ? data_wdata_i : '0;
        push           = mem_req_o && mem_gnt_i;
        pop            = mem_rvalid_i && (count_q != '0);
        head           = ids_q[rd_q];
        instr_gnt_o    = push && !sel;
        data_gnt_o     = push && sel;
        instr_rvalid_o = pop && !head;
        data_rvalid_o  = pop && head;
        instr_err_o    = instr_rvalid_o && mem_err_i;
        data_err_o     = data_rvalid_o && mem_err_i;
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
        outstanding_o  = count_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= 1'b1;
            prio_q  <= 1'b1;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ids_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel;
            if (push) begin
                prio_q      <= !sel;
                ids_q[wr_q] <= sel;
                wr_q        <= inc(wr_q);
            end
            if (pop)
                rd_q <= inc(rd_q);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mem_rvalid_i && count_q == '0))
        else $warning("spurious mem_rvalid_i dropped with no outstanding request");

endmodule
